// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared PWM constants, FSM states and scancode matcher
package pwm_pkg;

  localparam int PWM_PERIOD = 801;
  localparam int NOM_F = 41;
  localparam int NOM_Q = 51;
  localparam int NOM_H = 61;
  localparam int NOM_X = 81;

  localparam logic [7:0] SC_F = 8'h2B;
  localparam logic [7:0] SC_Q = 8'h15;
  localparam logic [7:0] SC_H = 8'h33;
  localparam logic [7:0] SC_X = 8'h22;
  localparam logic [7:0] SC_NONE = 8'h00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  function automatic logic in_window(input int h, input int nom, input int tol);
    return (h >= nom - tol) && (h <= nom + tol);
  endfunction

  // Windows are disjoint for tol < 5, so the check order does not matter.
  function automatic logic [7:0] match_code(input logic [9:0] h, input int tol);
    int hv;
    hv = int'({22'd0, h});
    if (in_window(hv, NOM_F, tol)) return SC_F;
    if (in_window(hv, NOM_Q, tol)) return SC_Q;
    if (in_window(hv, NOM_H, tol)) return SC_H;
    if (in_window(hv, NOM_X, tol)) return SC_X;
    return SC_NONE;
  endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// rtl/pwm_tick_gen.sv - free-running prescaler emitting one tick every PRESCALE cycles
module pwm_tick_gen #(
  parameter int PRESCALE = 625
) (
  input  logic clkdiv4,
  input  logic reset,
  output logic tick
);

  localparam int W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [W-1:0] cnt;

  assign tick = (cnt == W'(PRESCALE - 1));

  always_ff @(posedge clkdiv4 or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/pwm_decode.sv
// rtl/pwm_decode.sv - measures PWM high time and period, recovers the PS/2 scancode
module pwm_decode
  import pwm_pkg::*;
#(
  parameter int PRESCALE = 625,
  parameter int TOL      = 2,
  parameter int TIMEOUT  = 1023
) (
  input  logic       clkdiv4,
  input  logic       reset,
  input  logic       pwm_in,
  output logic [9:0] high_cnt,
  output logic [9:0] period_cnt,
  output logic [7:0] scancode,
  output logic       valid,
  output logic       timeout
);

  localparam logic [9:0] LIMIT = 10'(TIMEOUT);

  state_t     state, next_state;
  logic       sync1, s, s_d;
  logic       rise, fall, tick;
  logic [9:0] hcnt, pcnt;
  logic       clr, latch, lose;

  pwm_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .clkdiv4 (clkdiv4),
    .reset   (reset),
    .tick    (tick)
  );

  always_ff @(posedge clkdiv4 or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
      s_d   <= 1'b0;
    end else begin
      sync1 <= pwm_in;
      s     <= sync1;
      s_d   <= s;
    end
  end

  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

  always_ff @(posedge clkdiv4 or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Edges take priority over the loss check so a period ending right at the limit is still reported.
  always_comb begin
    next_state = state;
    clr        = 1'b0;
    latch      = 1'b0;
    lose       = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          clr        = 1'b1;
          next_state = HIGH;
        end
      end
      HIGH: begin
        if (fall) begin
          next_state = LOW;
        end else if (pcnt == LIMIT) begin
          lose       = 1'b1;
          next_state = IDLE;
        end
      end
      LOW: begin
        if (rise) begin
          latch      = 1'b1;
          clr        = 1'b1;
          next_state = HIGH;
        end else if (pcnt == LIMIT) begin
          lose       = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // hcnt still takes the tick of the falling-edge cycle; it freezes once in LOW.
  always_ff @(posedge clkdiv4 or posedge reset) begin
    if (reset) begin
      hcnt <= '0;
      pcnt <= '0;
    end else if (clr) begin
      hcnt <= '0;
      pcnt <= '0;
    end else if (tick) begin
      if (state == HIGH && hcnt != LIMIT) hcnt <= hcnt + 10'd1;
      if (state != IDLE && pcnt != LIMIT) pcnt <= pcnt + 10'd1;
    end
  end

  always_ff @(posedge clkdiv4 or posedge reset) begin
    if (reset) begin
      high_cnt   <= '0;
      period_cnt <= '0;
      scancode   <= SC_NONE;
      valid      <= 1'b0;
      timeout    <= 1'b1;
    end else begin
      valid <= latch;
      if (latch) begin
        high_cnt   <= hcnt;
        period_cnt <= pcnt;
        scancode   <= match_code(hcnt, TOL);
        timeout    <= 1'b0;
      end else if (lose) begin
        high_cnt   <= '0;
        period_cnt <= '0;
        scancode   <= SC_NONE;
        timeout    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_decode.sv
// tb/tb_pwm_decode.sv - randomized self-checking bench for pwm_decode
module tb_pwm_decode;

  typedef struct {
    int         h;
    int         p;
    logic [7:0] sc;
    logic       to;
  } res_t;

  logic       clkdiv4;
  logic       reset;
  logic       pwm_in;
  logic [9:0] high_cnt;
  logic [9:0] period_cnt;
  logic [7:0] scancode;
  logic       valid;
  logic       timeout;

  int   n_checks = 0;
  int   n_fail   = 0;
  res_t exp_q[$];
  res_t cap_q[$];
  logic prev_valid = 1'b0;

  pwm_decode #(.PRESCALE(1), .TOL(2), .TIMEOUT(1023)) dut (
    .clkdiv4    (clkdiv4),
    .reset      (reset),
    .pwm_in     (pwm_in),
    .high_cnt   (high_cnt),
    .period_cnt (period_cnt),
    .scancode   (scancode),
    .valid      (valid),
    .timeout    (timeout)
  );

  initial clkdiv4 = 1'b0;
  always #5 clkdiv4 = ~clkdiv4;

  always @(negedge clkdiv4) begin
    if (valid) begin
      cap_q.push_back('{int'(high_cnt), int'(period_cnt), scancode, timeout});
      n_checks++;
      if (prev_valid) begin
        n_fail++;
        $display("FAIL valid_width: valid high on two consecutive cycles, required single-cycle pulse");
      end
    end
    prev_valid = valid;
  end

  // Nominal high times in ticks and their scancodes, matched within +/-2 ticks.
  function automatic logic [7:0] ref_code(input int h);
    int         noms[4];
    logic [7:0] codes[4];
    noms  = '{41, 51, 61, 81};
    codes = '{8'h2B, 8'h15, 8'h33, 8'h22};
    for (int i = 0; i < 4; i++) begin
      if (h - noms[i] <= 2 && noms[i] - h <= 2) return codes[i];
    end
    return 8'h00;
  endfunction

  task automatic seg(input logic v, input int n);
    pwm_in = v;
    repeat (n) begin
      @(posedge clkdiv4);
      #1;
    end
  endtask

  // A period is measured from the cycle of its opening rise: high = h ticks, period = h+l-1 ticks.
  task automatic period(input int h, input int l);
    seg(1'b1, h);
    seg(1'b0, l);
    exp_q.push_back('{h, h + l - 1, ref_code(h), 1'b0});
  endtask

  task automatic do_reset();
    pwm_in = 1'b0;
    @(posedge clkdiv4);
    #1;
    reset = 1'b1;
    repeat (3) @(posedge clkdiv4);
    #1;
    reset = 1'b0;
    exp_q.delete();
    cap_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (timeout !== 1'b1 || valid !== 1'b0 || scancode !== 8'h00 || high_cnt !== 10'd0 || period_cnt !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_values: to=%b v=%b sc=%h h=%0d p=%0d, required to=1 v=0 sc=00 h=0 p=0",
               timeout, valid, scancode, high_cnt, period_cnt);
    end
    seg(1'b0, 1030);
    n_checks++;
    if (timeout !== 1'b1 || cap_q.size() != 0) begin
      n_fail++;
      $display("FAIL idle_quiet: to=%b valids=%0d, required to=1 valids=0", timeout, cap_q.size());
    end
  endtask

  task automatic test_periodic();
    do_reset();
    seg(1'b0, 20);
    period(41, 760);
    n_checks++;
    if (cap_q.size() != 0) begin
      n_fail++;
      $display("FAIL first_period_no_valid: valids=%0d, required 0", cap_q.size());
    end
    period(41, 760);
    period(41, 760);
    seg(1'b1, 6);
    n_checks++;
    if (cap_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL periodic_count: valids=%0d, required %0d", cap_q.size(), exp_q.size());
    end
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (cap_q[i].h != exp_q[i].h || cap_q[i].p != exp_q[i].p || cap_q[i].sc !== exp_q[i].sc || cap_q[i].to !== 1'b0) begin
        n_fail++;
        $display("FAIL periodic[%0d]: h=%0d p=%0d sc=%h to=%b, required h=%0d p=%0d sc=%h to=0",
                 i, cap_q[i].h, cap_q[i].p, cap_q[i].sc, cap_q[i].to, exp_q[i].h, exp_q[i].p, exp_q[i].sc);
      end
    end
  endtask

  task automatic test_duty_steps();
    do_reset();
    seg(1'b0, 10);
    period(51, 750);
    period(61, 740);
    period(81, 720);
    period(43, 758);
    period(44, 757);
    seg(1'b1, 6);
    n_checks++;
    if (cap_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL duty_count: valids=%0d, required %0d", cap_q.size(), exp_q.size());
    end
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (cap_q[i].h != exp_q[i].h || cap_q[i].p != exp_q[i].p || cap_q[i].sc !== exp_q[i].sc) begin
        n_fail++;
        $display("FAIL duty[%0d]: h=%0d p=%0d sc=%h, required h=%0d p=%0d sc=%h",
                 i, cap_q[i].h, cap_q[i].p, cap_q[i].sc, exp_q[i].h, exp_q[i].p, exp_q[i].sc);
      end
    end
  endtask

  task automatic test_random();
    int noms[4];
    int k, h, l;
    noms = '{41, 51, 61, 81};
    do_reset();
    seg(1'b0, 7);
    for (int i = 0; i < 8; i++) begin
      k = int'($urandom_range(0, 4));
      if (k < 4) h = noms[k] + int'($urandom_range(0, 6)) - 3;
      else       h = int'($urandom_range(20, 120));
      l = int'($urandom_range(500, 850));
      period(h, l);
    end
    seg(1'b1, 6);
    n_checks++;
    if (cap_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL random_count: valids=%0d, required %0d", cap_q.size(), exp_q.size());
    end
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (cap_q[i].h != exp_q[i].h || cap_q[i].p != exp_q[i].p || cap_q[i].sc !== exp_q[i].sc || cap_q[i].to !== 1'b0) begin
        n_fail++;
        $display("FAIL random[%0d]: h=%0d p=%0d sc=%h to=%b, required h=%0d p=%0d sc=%h to=0",
                 i, cap_q[i].h, cap_q[i].p, cap_q[i].sc, cap_q[i].to, exp_q[i].h, exp_q[i].p, exp_q[i].sc);
      end
    end
  endtask

  task automatic test_stuck_high();
    do_reset();
    seg(1'b0, 20);
    period(41, 760);
    seg(1'b1, 1000);
    n_checks++;
    if (cap_q.size() != 1 || timeout !== 1'b0 || scancode !== 8'h2B) begin
      n_fail++;
      $display("FAIL stuck_before_limit: valids=%0d to=%b sc=%h, required valids=1 to=0 sc=2b",
               cap_q.size(), timeout, scancode);
    end
    seg(1'b1, 100);
    n_checks++;
    if (timeout !== 1'b1 || scancode !== 8'h00 || high_cnt !== 10'd0 || period_cnt !== 10'd0 || cap_q.size() != 1) begin
      n_fail++;
      $display("FAIL stuck_timeout: to=%b sc=%h h=%0d p=%0d valids=%0d, required to=1 sc=00 h=0 p=0 valids=1",
               timeout, scancode, high_cnt, period_cnt, cap_q.size());
    end
    seg(1'b0, 50);
    exp_q.delete();
    cap_q.delete();
    period(51, 750);
    n_checks++;
    if (cap_q.size() != 0 || timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL resume_first_rise: valids=%0d to=%b, required valids=0 to=1", cap_q.size(), timeout);
    end
    seg(1'b1, 6);
    n_checks++;
    if (cap_q.size() != 1 || cap_q[0].h != 51 || cap_q[0].p != 800 || cap_q[0].sc !== 8'h15 || cap_q[0].to !== 1'b0) begin
      n_fail++;
      $display("FAIL resume_valid: valids=%0d, required one valid h=51 p=800 sc=15 to=0", cap_q.size());
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    seg(1'b0, 10);
    period(61, 740);
    seg(1'b1, 41);
    seg(1'b0, 259);
    reset = 1'b1;
    #2;
    n_checks++;
    if (timeout !== 1'b1 || valid !== 1'b0 || scancode !== 8'h00 || high_cnt !== 10'd0 || period_cnt !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_mid_values: to=%b v=%b sc=%h h=%0d p=%0d, required to=1 v=0 sc=00 h=0 p=0",
               timeout, valid, scancode, high_cnt, period_cnt);
    end
    @(posedge clkdiv4);
    #1;
    reset = 1'b0;
    cap_q.delete();
    exp_q.delete();
    seg(1'b0, 100);
    period(81, 720);
    n_checks++;
    if (cap_q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_mid_first: valids=%0d, required 0", cap_q.size());
    end
    seg(1'b1, 6);
    n_checks++;
    if (cap_q.size() != 1 || cap_q[0].h != exp_q[0].h || cap_q[0].p != exp_q[0].p || cap_q[0].sc !== exp_q[0].sc) begin
      n_fail++;
      $display("FAIL reset_mid_second: valids=%0d, required one valid h=%0d p=%0d sc=%h",
               cap_q.size(), exp_q[0].h, exp_q[0].p, exp_q[0].sc);
    end
  endtask

  initial begin
    reset  = 1'b1;
    pwm_in = 1'b0;
    test_reset();
    test_periodic();
    test_duty_steps();
    test_random();
    test_stuck_high();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
